// File: rtl/mem_access_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_stage_pkg
// Shared load/store funct3 encodings and small decode helpers used by the
// memory-access stage and its load alignment sub-module.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_access_stage_pkg;

  // Load widths / signedness
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store widths
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic load_f3_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic store_f3_legal(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

  // funct3[1:0] carries the access size for both loads and stores.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (f3[1:0])
      2'b10:   mis = (addr_lo != 2'b00);
      2'b01:   mis = addr_lo[0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// -----------------------------------------------------------------------------
// mem_load_align
// Purely combinational: picks the byte/half out of a read word using the low
// address bits and sign- or zero-extends it according to funct3.
// Ports:
//   rdata_i   [31:0] read word from data memory
//   addr_lo_i [1:0]  byte offset within the word
//   funct3_i  [2:0]  load width / signedness
//   data_o    [31:0] formatted load value
// -----------------------------------------------------------------------------
module mem_load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o   = rdata_i;
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data_o = {24'h000000, byte_sel};
      F3_LHU:  data_o = {16'h0000, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// Memory-access pipeline stage: takes the execute-stage outputs, performs a
// byte/half/word load or store over a single-outstanding valid/ready port and
// hands a write-back value plus a one-cycle completion pulse downstream.
// Ports:
//   CLK, RST_X                clock, asynchronous active-low reset
//   mem_req                   start pulse (only honoured in IDLE)
//   mem_addr, wr_mem_data     byte address, store data
//   result                    write-back value for non-load instructions
//   rd_mem, wr_mem            load / store flags
//   wr_regfile, funct3        rd write flag, width/signedness
//   dmem_valid/we/addr/wdata/wstrb   request to data memory
//   dmem_ready, dmem_rdata    memory handshake / read data
//   wb_data, wb_en            write-back value and enable
//   mem_done, mem_busy, mem_err      status
// -----------------------------------------------------------------------------
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int AWIDTH = 25
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic              mem_req,
  input  logic [AWIDTH-1:0] mem_addr,
  input  logic [31:0]       wr_mem_data,
  input  logic [31:0]       result,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic              wr_regfile,
  input  logic [2:0]        funct3,
  output logic              dmem_valid,
  output logic              dmem_we,
  output logic [AWIDTH-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       wb_data,
  output logic              wb_en,
  output logic              mem_done,
  output logic              mem_busy,
  output logic              mem_err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      state_q;
  logic [1:0]  addr_lo_q;
  logic [2:0]  funct3_q;
  logic        rd_mem_q;
  logic        wr_regfile_q;

  logic        req_err_d;
  logic [31:0] store_wdata_d;
  logic [3:0]  store_wstrb_d;
  logic [31:0] load_data;

  // Request legality, evaluated on the raw execute-stage inputs.
  always_comb begin
    req_err_d = 1'b0;
    if (rd_mem && wr_mem)
      req_err_d = 1'b1;
    else if (rd_mem)
      req_err_d = !load_f3_legal(funct3) || misaligned(funct3, mem_addr[1:0]);
    else if (wr_mem)
      req_err_d = !store_f3_legal(funct3) || misaligned(funct3, mem_addr[1:0]);
  end

  // Replicate the store datum into every lane it may land in; the strobe
  // selects which lane memory actually writes.
  always_comb begin
    store_wdata_d = wr_mem_data;
    store_wstrb_d = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        store_wdata_d = {4{wr_mem_data[7:0]}};
        store_wstrb_d = 4'b0001 << mem_addr[1:0];
      end
      2'b01: begin
        store_wdata_d = {2{wr_mem_data[15:0]}};
        store_wstrb_d = 4'b0011 << mem_addr[1:0];
      end
      default: begin
        store_wdata_d = wr_mem_data;
        store_wstrb_d = 4'b1111;
      end
    endcase
  end

  mem_load_align u_load_align (
    .rdata_i   (dmem_rdata),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .data_o    (load_data)
  );

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q      <= S_IDLE;
      addr_lo_q    <= 2'b00;
      funct3_q     <= 3'b000;
      rd_mem_q     <= 1'b0;
      wr_regfile_q <= 1'b0;
      dmem_valid   <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= 32'h0;
      dmem_wstrb   <= 4'h0;
      wb_data      <= 32'h0;
      wb_en        <= 1'b0;
      mem_done     <= 1'b0;
      mem_busy     <= 1'b0;
      mem_err      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mem_req) begin
            addr_lo_q    <= mem_addr[1:0];
            funct3_q     <= funct3;
            rd_mem_q     <= rd_mem;
            wr_regfile_q <= wr_regfile;
            mem_busy     <= 1'b1;
            if (req_err_d) begin
              // Faulting access: no bus cycle, report straight away.
              state_q  <= S_DONE;
              mem_done <= 1'b1;
              mem_err  <= 1'b1;
              wb_en    <= 1'b0;
              wb_data  <= 32'h0;
            end else if (rd_mem || wr_mem) begin
              state_q    <= S_ACCESS;
              dmem_valid <= 1'b1;
              dmem_we    <= wr_mem;
              dmem_addr  <= {mem_addr[AWIDTH-1:2], 2'b00};
              dmem_wdata <= wr_mem ? store_wdata_d : 32'h0;
              dmem_wstrb <= wr_mem ? store_wstrb_d : 4'h0;
              mem_err    <= 1'b0;
              wb_en      <= 1'b0;
              wb_data    <= 32'h0;
            end else begin
              state_q  <= S_DONE;
              mem_done <= 1'b1;
              mem_err  <= 1'b0;
              wb_data  <= result;
              wb_en    <= wr_regfile;
            end
          end
        end
        S_ACCESS: begin
          if (dmem_ready) begin
            state_q    <= S_DONE;
            dmem_valid <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wstrb <= 4'h0;
            mem_done   <= 1'b1;
            if (rd_mem_q) begin
              wb_data <= load_data;
              wb_en   <= wr_regfile_q;
            end else begin
              wb_en   <= 1'b0;
            end
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          mem_done <= 1'b0;
          mem_busy <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int AW = 25;

  logic          CLK;
  logic          RST_X;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [31:0]   wr_mem_data;
  logic [31:0]   result;
  logic          rd_mem;
  logic          wr_mem;
  logic          wr_regfile;
  logic [2:0]    funct3;
  logic          dmem_valid;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata;
  logic [3:0]    dmem_wstrb;
  logic          dmem_ready;
  logic [31:0]   dmem_rdata;
  logic [31:0]   wb_data;
  logic          wb_en;
  logic          mem_done;
  logic          mem_busy;
  logic          mem_err;

  int n_vec = 0;
  int n_err = 0;

  mem_access_stage #(.AWIDTH(AW)) dut (
    .CLK         (CLK),
    .RST_X       (RST_X),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .wr_mem_data (wr_mem_data),
    .result      (result),
    .rd_mem      (rd_mem),
    .wr_mem      (wr_mem),
    .wr_regfile  (wr_regfile),
    .funct3      (funct3),
    .dmem_valid  (dmem_valid),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_wstrb  (dmem_wstrb),
    .dmem_ready  (dmem_ready),
    .dmem_rdata  (dmem_rdata),
    .wb_data     (wb_data),
    .wb_en       (wb_en),
    .mem_done    (mem_done),
    .mem_busy    (mem_busy),
    .mem_err     (mem_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (arithmetic on the rules) --------------
  function automatic int acc_size(input logic [2:0] f3);
    int sz;
    sz = 2 ** (int'(f3) % 4);
    return sz;
  endfunction

  function automatic bit model_err(input bit rd, input bit wr, input logic [2:0] f3,
                                   input logic [AW-1:0] a);
    int f;
    f = int'(f3);
    if (rd && wr) return 1'b1;
    if (rd) begin
      if (!(f == 0 || f == 1 || f == 2 || f == 4 || f == 5)) return 1'b1;
      return (int'(a) % acc_size(f3)) != 0;
    end
    if (wr) begin
      if (f > 2) return 1'b1;
      return (int'(a) % acc_size(f3)) != 0;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd_word,
                                             input logic [AW-1:0] a, input logic [2:0] f3);
    int off;
    int sz;
    logic [31:0] v;
    off = int'(a) % 4;
    sz  = acc_size(f3);
    if (sz == 4) return rd_word;
    v = rd_word >> (8 * off);
    if (sz == 2) begin
      v = v & 32'h0000FFFF;
      if (int'(f3) < 4 && v >= 32'h00008000) v = v | 32'hFFFF0000;
    end else begin
      v = v & 32'h000000FF;
      if (int'(f3) < 4 && v >= 32'h00000080) v = v | 32'hFFFFFF00;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_strb(input logic [AW-1:0] a, input logic [2:0] f3);
    int m;
    logic [31:0] t;
    m = ((1 << acc_size(f3)) - 1) << (int'(a) % 4);
    t = m;
    return t[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [2:0] f3);
    logic [31:0] w;
    int sz;
    sz = acc_size(f3);
    w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
    return w;
  endfunction

  // ---------------- one complete transaction --------------------------------
  task automatic run_op(input string tag, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [31:0] res, input bit rd, input bit wr, input bit wrf,
                        input logic [2:0] f3, input int waits, input logic [31:0] rdw,
                        input bit spurious);
    bit            e;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_wb;
    e        = model_err(rd, wr, f3, a);
    exp_addr = (a / 4) * 4;
    @(negedge CLK);
    mem_req = 1'b1; mem_addr = a; wr_mem_data = d; result = res;
    rd_mem = rd; wr_mem = wr; wr_regfile = wrf; funct3 = f3;
    dmem_ready = 1'b0;
    @(negedge CLK);
    mem_req = 1'b0;
    chk({tag, ".busy"}, {31'b0, mem_busy}, 32'd1);
    if (e || !(rd || wr)) begin
      chk({tag, ".done"}, {31'b0, mem_done}, 32'd1);
      chk({tag, ".valid"}, {31'b0, dmem_valid}, 32'd0);
      chk({tag, ".err"}, {31'b0, mem_err}, {31'b0, e});
      chk({tag, ".wb_en"}, {31'b0, wb_en}, {31'b0, !e && wrf});
      if (!e) chk({tag, ".wb_data"}, wb_data, res);
    end else begin
      chk({tag, ".valid"}, {31'b0, dmem_valid}, 32'd1);
      chk({tag, ".we"}, {31'b0, dmem_we}, {31'b0, wr});
      chk({tag, ".addr"}, 32'(dmem_addr), 32'(exp_addr));
      chk({tag, ".strb"}, {28'b0, dmem_wstrb}, wr ? {28'b0, model_strb(a, f3)} : 32'd0);
      if (wr) chk({tag, ".wdata"}, dmem_wdata, model_wdata(d, f3));
      chk({tag, ".early_done"}, {31'b0, mem_done}, 32'd0);
      for (int w = 0; w < waits; w++) begin
        if (spurious) begin
          mem_req = 1'b1; mem_addr = ~a; wr_mem_data = ~d; rd_mem = 1'b1; wr_mem = 1'b0;
          funct3 = 3'b010; wr_regfile = 1'b1;
        end
        dmem_rdata = $urandom;
        @(negedge CLK);
        chk({tag, ".hold_valid"}, {31'b0, dmem_valid}, 32'd1);
        chk({tag, ".hold_addr"}, 32'(dmem_addr), 32'(exp_addr));
        if (wr) chk({tag, ".hold_wdata"}, dmem_wdata, model_wdata(d, f3));
      end
      mem_req = 1'b0;
      dmem_ready = 1'b1; dmem_rdata = rdw;
      @(negedge CLK);
      dmem_ready = 1'b0; dmem_rdata = $urandom;
      exp_wb = model_load(rdw, a, f3);
      chk({tag, ".done"}, {31'b0, mem_done}, 32'd1);
      chk({tag, ".valid_off"}, {31'b0, dmem_valid}, 32'd0);
      chk({tag, ".err"}, {31'b0, mem_err}, 32'd0);
      chk({tag, ".wb_en"}, {31'b0, wb_en}, {31'b0, rd && wrf});
      if (rd) chk({tag, ".wb_data"}, wb_data, exp_wb);
    end
    @(negedge CLK);
    chk({tag, ".done_pulse"}, {31'b0, mem_done}, 32'd0);
    chk({tag, ".idle"}, {31'b0, mem_busy}, 32'd0);
    chk({tag, ".no_new"}, {31'b0, dmem_valid}, 32'd0);
    $display("op %s addr=%h f3=%0d rd=%0d wr=%0d waits=%0d err=%0d wb=%h/%0d",
             tag, a, f3, rd, wr, waits, mem_err, wb_data, wb_en);
  endtask

  initial begin
    logic [31:0] r0, r1, r2, r3;
    int k;
    bit rd, wr;
    logic [2:0] f3;
    logic [AW-1:0] a;
    int sz;

    RST_X = 1'b0; mem_req = 1'b0; mem_addr = '0; wr_mem_data = '0; result = '0;
    rd_mem = 1'b0; wr_mem = 1'b0; wr_regfile = 1'b0; funct3 = 3'b000;
    dmem_ready = 1'b0; dmem_rdata = '0;
    repeat (3) @(negedge CLK);
    chk("rst.valid", {31'b0, dmem_valid}, 32'd0);
    chk("rst.done", {31'b0, mem_done}, 32'd0);
    chk("rst.busy", {31'b0, mem_busy}, 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    chk("rst.wstrb", {28'b0, dmem_wstrb}, 32'd0);
    RST_X = 1'b1;
    @(negedge CLK);

    // directed
    run_op("nonmem", 25'h0, 32'h0, 32'h1234, 0, 0, 1, 3'b000, 0, 32'h0, 0);
    run_op("LB", 25'h003, 32'h0, 32'h0, 1, 0, 1, 3'b000, 3, 32'h80FFFFFF, 0);
    run_op("LBU", 25'h003, 32'h0, 32'h0, 1, 0, 1, 3'b100, 3, 32'h80FFFFFF, 0);
    run_op("SH", 25'h006, 32'hDEADBEEF, 32'h0, 0, 1, 1, 3'b001, 1, 32'h0, 0);
    run_op("LW_mis", 25'h002, 32'h0, 32'h0, 1, 0, 1, 3'b010, 0, 32'h0, 0);
    run_op("LD_ST", 25'h008, 32'h0, 32'h0, 1, 1, 1, 3'b010, 0, 32'h0, 0);
    run_op("LH_spur", 25'h00A, 32'h0, 32'h0, 1, 0, 1, 3'b001, 3, 32'h9ABC1234, 1);

    // reset in the middle of an access
    @(negedge CLK);
    mem_req = 1'b1; mem_addr = 25'h020; rd_mem = 1'b1; wr_mem = 1'b0; funct3 = 3'b010;
    wr_regfile = 1'b1;
    @(negedge CLK);
    mem_req = 1'b0;
    chk("rstmid.valid_before", {31'b0, dmem_valid}, 32'd1);
    #2 RST_X = 1'b0;
    #1;
    chk("rstmid.valid", {31'b0, dmem_valid}, 32'd0);
    chk("rstmid.busy", {31'b0, mem_busy}, 32'd0);
    chk("rstmid.wb_en", {31'b0, wb_en}, 32'd0);
    chk("rstmid.addr", 32'(dmem_addr), 32'd0);
    dmem_ready = 1'b1;
    @(negedge CLK);
    chk("rstmid.no_done", {31'b0, mem_done}, 32'd0);
    dmem_ready = 1'b0;
    RST_X = 1'b1;
    @(negedge CLK);
    chk("rstmid.after_done", {31'b0, mem_done}, 32'd0);
    r0 = $urandom;
    run_op("LW_post", 25'h010, 32'h0, 32'h0, 1, 0, 1, 3'b010, 1, r0, 0);

    // randomized
    for (int i = 0; i < 80; i++) begin
      r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
      k = $urandom_range(0, 9);
      rd = (k >= 2 && k <= 5) || k == 9;
      wr = (k >= 6);
      if ($urandom_range(0, 4) == 0) f3 = r3[2:0];
      else if (rd) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
        endcase
      end else begin
        k = $urandom_range(0, 2);
        f3 = 3'(k);
      end
      a = r0[AW-1:0];
      sz = acc_size(f3);
      if ($urandom_range(0, 3) != 0) a = (a / AW'(sz)) * AW'(sz);
      run_op("rand", a, r1, r2, rd, wr, r3[8], f3, $urandom_range(0, 3), r3, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage sitting directly downstream of the execute stage. Consumes the execute outputs (effective address, store data, load/store/regfile-write flags, ALU result) plus the instruction's funct3. Performs byte/half/word loads and stores over a single-outstanding valid/ready data-memory port, then presents the write-back value and a one-cycle completion pulse to the write-back stage.

## Interface
- AWIDTH, 25, byte-address width of data memory (matches execute-stage mem_addr)
- CLK  in  1  clock, all state on rising edge
- RST_X  in  1  asynchronous, active-low reset
- mem_req  in  1  start pulse; sampled only in IDLE
- mem_addr  in  AWIDTH  byte address from execute stage
- wr_mem_data  in  32  store data (rs2)
- result  in  32  execute result, used as write-back value for non-loads
- rd_mem  in  1  instruction is a load
- wr_mem  in  1  instruction is a store
- wr_regfile  in  1  instruction writes rd
- funct3  in  3  load/store width and signedness
- dmem_valid  out  1  memory request valid
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  AWIDTH  word-aligned address, low 2 bits 0
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables (0000 on reads)
- dmem_ready  in  1  memory accepts/completes the request this cycle
- dmem_rdata  in  32  read word, valid when dmem_ready high on a read
- wb_data  out  32  write-back value
- wb_en  out  1  write-back enable
- mem_done  out  1  one-cycle completion pulse
- mem_busy  out  1  high whenever state is not IDLE
- mem_err  out  1  misaligned access or illegal funct3; valid with mem_done

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE + mem_req: latch all inputs. Error check: word access with addr[1:0] != 0, half with addr[0] != 0, load funct3 not in {000,001,010,100,101}, store funct3 not in {000,001,010} → DONE with mem_err=1, wb_en=0, no bus cycle. Else if rd_mem or wr_mem → ACCESS. Else → DONE with wb_data=result, wb_en=wr_regfile.
- rd_mem and wr_mem both set: treated as illegal → mem_err.
- ACCESS: dmem_valid held high, all dmem_* outputs stable until dmem_ready sampled high; then → DONE.
- Load: select byte/half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass; wb_data = formatted value, wb_en=wr_regfile.
- Store: SB wdata={4{b}}, wstrb=0001<<addr[1:0]; SH wdata={2{h}}, wstrb=0011<<addr[1:0]; SW wdata as-is, wstrb=1111; wb_en=0.
- DONE: mem_done=1 for exactly one cycle → IDLE.
- mem_req while not IDLE ignored (no queueing).

## Timing
- Reset values: state IDLE, every output 0.
- Reset asserted mid-ACCESS: dmem_valid drops asynchronously; the access is abandoned; no mem_done.
- All outputs registered; no combinational path from mem_req or dmem_ready to any output.
- Non-memory op: mem_req sampled at edge k → mem_done high in cycle k+1.
- Memory op: dmem_valid high from edge k; dmem_ready sampled high at edge j (j ≥ k+1) → mem_done high in cycle j+1. Zero-wait memory gives 2-cycle latency.
- wb_data, wb_en, mem_err held after mem_done until the next accepted mem_req.
- mem_busy = 1 from edge k until the edge ending the DONE cycle.

## Structure
- Load/store funct3 encodings (LB, LH, LW, LBU, LHU, SB, SH, SW) added to the shared funct header; FSM state encodings stay local.
- One combinational sub-module, mem_load_align: (rdata, addr[1:0], funct3) → formatted 32-bit load value.
- Store lane replication and strobe generation stay inline.

## Test plan
- mem_req with rd_mem=0, wr_mem=0, wr_regfile=1, result=0x1234 → mem_done next cycle, wb_data=0x1234, wb_en=1, dmem_valid never high.
- LB addr=0x003, rdata=0x80FFFFFF, dmem_ready after 3 wait cycles → dmem_addr=0x000, wb_data=0xFFFFFF80; repeat LBU → 0x00000080.
- SH addr=0x006, wr_mem_data=0xDEADBEEF → dmem_we=1, dmem_addr=0x004, wstrb=1100, wdata=0xBEEFBEEF, wb_en=0.
- LW addr=0x002 → mem_err=1, wb_en=0, no dmem_valid, mem_done next cycle.
- Second mem_req during ACCESS → ignored; only one mem_done pulse; latched inputs unchanged.
- RST_X low during ACCESS → dmem_valid 0 immediately, all outputs 0; after release, a new LW at 0x010 completes normally.
